// File: rtl/exec_sequencer.sv
// Multi-cycle control sequencer for the cirno datapath: one registered strobe per phase.
// Optional performance counters are built when EXEC_SEQ_PERF_COUNT_EN is defined.
module exec_sequencer #(
  parameter int unsigned MEM_WAIT = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [2:0]       inst_type,
  output logic             fetch_unit_en,
  output logic             decoder_en,
  output logic             reg_r_en,
  output logic             alu_en,
  output logic             reg_w_en,
  output logic             memory_w_en,
  output logic             memory_r_en,
  output logic             reg_mem_w_en,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] inst_count,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int unsigned WAIT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

  localparam logic [2:0] T_NIL  = 3'd2;
  localparam logic [2:0] T_MV   = 3'd3;
  localparam logic [2:0] T_ST   = 3'd5;
  localparam logic [2:0] T_LD   = 3'd6;
  localparam logic [2:0] T_HALT = 3'd7;
  localparam logic [2:0] T_ALU  = 3'd1;
  localparam logic [2:0] T_JMP  = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_DISPATCH, S_OF, S_ALU,
    S_RS, S_WM, S_RM, S_RMS, S_HALT
  } state_t;

  state_t            state, state_n;
  logic [2:0]        type_q;
  logic [WAIT_W-1:0] wait_q;
  logic              illegal_c;

  // Next-state decode; init outside IDLE abandons whatever is in flight.
  always_comb begin
    state_n   = state;
    illegal_c = 1'b0;
    case (state)
      S_IDLE:     if (init) state_n = S_FETCH;
      S_FETCH:    state_n = S_DECODE;
      S_DECODE:   state_n = S_DISPATCH;
      S_DISPATCH: begin
        case (inst_type)
          T_ALU, T_JMP, T_ST, T_LD: state_n = S_OF;
          T_MV:                     state_n = S_RS;
          T_NIL:                    state_n = S_FETCH;
          T_HALT:                   state_n = S_HALT;
          default: begin
            state_n   = S_FETCH;
            illegal_c = 1'b1;
          end
        endcase
      end
      S_OF: begin
        case (type_q)
          T_ALU:   state_n = S_ALU;
          T_ST:    state_n = S_WM;
          T_LD:    state_n = S_RM;
          default: state_n = S_FETCH;
        endcase
      end
      S_ALU:   state_n = S_RS;
      S_RS:    state_n = S_FETCH;
      S_WM:    if (wait_q == '0) state_n = S_FETCH;
      S_RM:    if (wait_q == '0) state_n = S_RMS;
      S_RMS:   state_n = S_FETCH;
      S_HALT:  state_n = S_HALT;
      default: state_n = S_IDLE;
    endcase
    if (init && (state != S_IDLE)) begin
      state_n   = S_FETCH;
      illegal_c = 1'b0;
    end
  end

  // State, latched class, memory wait counter and strobes decoded from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      type_q        <= '0;
      wait_q        <= '0;
      fetch_unit_en <= 1'b0;
      decoder_en    <= 1'b0;
      reg_r_en      <= 1'b0;
      alu_en        <= 1'b0;
      reg_w_en      <= 1'b0;
      memory_w_en   <= 1'b0;
      memory_r_en   <= 1'b0;
      reg_mem_w_en  <= 1'b0;
      done          <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      state <= state_n;
      if (state == S_DISPATCH) type_q <= inst_type;
      if ((state_n == S_WM || state_n == S_RM) && (state_n != state)) begin
        wait_q <= WAIT_W'(MEM_WAIT);
      end else if ((state == S_WM || state == S_RM) && (wait_q != '0)) begin
        wait_q <= wait_q - WAIT_W'(1);
      end
      fetch_unit_en <= (state_n == S_FETCH);
      decoder_en    <= (state_n == S_DECODE);
      reg_r_en      <= (state_n == S_OF);
      alu_en        <= (state_n == S_ALU);
      reg_w_en      <= (state_n == S_RS);
      memory_w_en   <= (state_n == S_WM);
      memory_r_en   <= (state_n == S_RM);
      reg_mem_w_en  <= (state_n == S_RMS);
      done          <= (state_n == S_HALT);
      illegal       <= illegal_c;
    end
  end

`ifdef EXEC_SEQ_PERF_COUNT_EN
  logic             retire_c;
  logic [CNT_W-1:0] inst_q;
  logic [CNT_W-1:0] cyc_q;

  // An instruction retires on its completing move into FETCH or into HALT.
  assign retire_c = !init && (state != S_HALT) &&
                    ((state_n == S_FETCH) || (state_n == S_HALT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inst_q <= '0;
      cyc_q  <= '0;
    end else if (init) begin
      inst_q <= '0;
      cyc_q  <= '0;
    end else begin
      if (retire_c) inst_q <= inst_q + CNT_W'(1);
      if ((state != S_IDLE) && (state != S_HALT)) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign inst_count  = inst_q;
  assign cycle_count = cyc_q;
`else
  assign inst_count  = '0;
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: per-class strobe sequences from a table model,
// directed scenarios followed by randomized instruction streams with init/reset aborts.
module tb_exec_sequencer;

  localparam int unsigned MEM_WAIT = 2;
  localparam int unsigned CNT_W    = 4;

  typedef logic [9:0] vec_t;
  localparam vec_t V_F   = 10'b10_0000_0000;
  localparam vec_t V_D   = 10'b01_0000_0000;
  localparam vec_t V_RR  = 10'b00_1000_0000;
  localparam vec_t V_ALU = 10'b00_0100_0000;
  localparam vec_t V_RW  = 10'b00_0010_0000;
  localparam vec_t V_MW  = 10'b00_0001_0000;
  localparam vec_t V_MR  = 10'b00_0000_1000;
  localparam vec_t V_RMW = 10'b00_0000_0100;
  localparam vec_t V_DN  = 10'b00_0000_0010;
  localparam vec_t V_I   = 10'b00_0000_0001;
  localparam vec_t V_0   = 10'b00_0000_0000;

  logic             clk;
  logic             rst_n;
  logic             init;
  logic [2:0]       inst_type;
  logic             fetch_unit_en, decoder_en, reg_r_en, alu_en, reg_w_en;
  logic             memory_w_en, memory_r_en, reg_mem_w_en, done, illegal;
  logic [CNT_W-1:0] inst_count, cycle_count;

  exec_sequencer #(.MEM_WAIT(MEM_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .init(init), .inst_type(inst_type),
    .fetch_unit_en(fetch_unit_en), .decoder_en(decoder_en), .reg_r_en(reg_r_en),
    .alu_en(alu_en), .reg_w_en(reg_w_en), .memory_w_en(memory_w_en),
    .memory_r_en(memory_r_en), .reg_mem_w_en(reg_mem_w_en), .done(done),
    .illegal(illegal), .inst_count(inst_count), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t obs;
  assign obs = {fetch_unit_en, decoder_en, reg_r_en, alu_en, reg_w_en,
                memory_w_en, memory_r_en, reg_mem_w_en, done, illegal};

  int               n_cmp = 0;
  int               n_err = 0;
  logic [CNT_W-1:0] exp_inst;
  logic [CNT_W-1:0] exp_cyc;
  vec_t             seq [0:15];
  int               seq_len;
  bit               pend_ill;
  bit               halted;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_vec(input string tag, input vec_t got, input vec_t exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s strobes got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] got,
                         input logic [CNT_W-1:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_now(input string tag, input vec_t e);
    chk_vec(tag, obs, e);
`ifdef EXEC_SEQ_PERF_COUNT_EN
    chk_cnt({tag, ".inst_count"}, inst_count, exp_inst);
    chk_cnt({tag, ".cycle_count"}, cycle_count, exp_cyc);
`else
    chk_cnt({tag, ".inst_count"}, inst_count, '0);
    chk_cnt({tag, ".cycle_count"}, cycle_count, '0);
`endif
  endtask

  task automatic push(input vec_t v);
    seq[seq_len] = v;
    seq_len++;
  endtask

  // Strobe sequence of one instruction class, starting at its fetch cycle.
  task automatic build(input logic [2:0] t);
    seq_len = 0;
    push(V_F); push(V_D); push(V_0);
    case (t)
      3'd1: begin push(V_RR); push(V_ALU); push(V_RW); end
      3'd3: push(V_RW);
      3'd4: push(V_RR);
      3'd5: begin push(V_RR); for (int j = 0; j <= int'(MEM_WAIT); j++) push(V_MW); end
      3'd6: begin
        push(V_RR);
        for (int j = 0; j <= int'(MEM_WAIT); j++) push(V_MR);
        push(V_RMW);
      end
      default: ;
    endcase
  endtask

  task automatic start();
    init = 1'b1;
    tick();
    init = 1'b0;
    exp_cyc  = '0;
    exp_inst = '0;
    pend_ill = 1'b0;
    halted   = 1'b0;
  endtask

  // mode 0: run to completion; 1: init at cycle k; 2: reset at cycle k.
  task automatic run_inst(input logic [2:0] t, input int mode, input int k_raw);
    int   k;
    vec_t e;
    build(t);
    k = k_raw % seq_len;
    for (int i = 0; i < seq_len; i++) begin
      e = seq[i];
      if (i == 0 && pend_ill) e = e | V_I;
      check_now($sformatf("type%0d.c%0d", t, i), e);
      if (mode == 1 && i == k) begin
        start();
        return;
      end
      if (mode == 2 && i == k) begin
        rst_n = 1'b0;
        init  = 1'b1;
        tick();
        exp_cyc = '0; exp_inst = '0; pend_ill = 1'b0; halted = 1'b0;
        check_now("midreset", V_0);
        rst_n = 1'b1;
        init  = 1'b0;
        tick();
        check_now("postreset_idle", V_0);
        start();
        return;
      end
      inst_type = (i <= 2) ? t : 3'($urandom_range(7, 0));
      tick();
      exp_cyc++;
    end
    exp_inst++;
    pend_ill = (t == 3'd0);
    halted   = (t == 3'd7);
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      check_now("halt", V_DN);
      inst_type = 3'($urandom_range(7, 0));
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; init = 1'b1; inst_type = 3'd0;
    exp_cyc = '0; exp_inst = '0; pend_ill = 1'b0; halted = 1'b0;
    tick();
    check_now("reset1", V_0);
    tick();
    check_now("reset2", V_0);
    rst_n = 1'b1; init = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_now("idle", V_0);
    end

    // ALU class, then memory classes with stretched access
    start();
    run_inst(3'd1, 0, 0);
    run_inst(3'd6, 0, 0);
    run_inst(3'd5, 0, 0);
    run_inst(3'd2, 0, 0);

    // Short classes ending in halt, then restart from halt
    start();
    run_inst(3'd2, 0, 0);
    run_inst(3'd3, 0, 0);
    run_inst(3'd4, 0, 0);
    run_inst(3'd7, 0, 0);
    halt_hold(10);
    start();

    // Illegal class, then abandon an ALU instruction in its ALU phase
    run_inst(3'd0, 0, 0);
    run_inst(3'd2, 0, 0);
    run_inst(3'd1, 1, 4);
    run_inst(3'd2, 0, 0);

    // Counter wrap after 17 retires
    start();
    for (int i = 0; i < 17; i++) run_inst(3'd2, 0, 0);
    run_inst(3'd7, 0, 0);
    halt_hold(2);
    start();

    // Randomized instruction stream with occasional aborts
    for (int n = 0; n < 300; n++) begin
      int r;
      if (halted) begin
        halt_hold(int'($urandom_range(3, 1)));
        start();
      end
      r = int'($urandom_range(19, 0));
      run_inst(3'($urandom_range(7, 0)), (r < 2) ? 2 : ((r < 5) ? 1 : 0),
               int'($urandom_range(15, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
